// File: rtl/multi_pio.sv
// multi_pio: Avalon-MM PIO with IN_WIDTH synchronised, debounced, edge-captured
// inputs, OUT_WIDTH outputs and per-hart masked edge interrupts.
// Optional feature macro: MULTI_PIO_DEBOUNCE_EN (per-bit debounce counters).
// Without it the debounced input is the synchroniser output directly.
module multi_pio #(
    parameter int                   IN_WIDTH        = 4,
    parameter int                   OUT_WIDTH       = 4,
    parameter int                   NUM_HARTS       = 2,
    parameter int                   DEBOUNCE_CYCLES = 50000,
    parameter logic [IN_WIDTH-1:0]  IN_RESET        = {IN_WIDTH{1'b0}},
    parameter logic [OUT_WIDTH-1:0] OUT_RESET       = {OUT_WIDTH{1'b0}}
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [3:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    input  logic [IN_WIDTH-1:0]  pio_in_export,
    output logic [OUT_WIDTH-1:0] pio_out_export,
    output logic [NUM_HARTS-1:0] irq
);

    localparam logic [3:0] ADDR_DATA_IN  = 4'd0;
    localparam logic [3:0] ADDR_DATA_OUT = 4'd1;
    localparam logic [3:0] ADDR_SET_OUT  = 4'd2;
    localparam logic [3:0] ADDR_CLR_OUT  = 4'd3;
    localparam logic [3:0] ADDR_EDGE_CAP = 4'd4;
    localparam logic [3:0] ADDR_EDGE_POL = 4'd5;
    localparam int         MASK_BASE     = 6;
    localparam logic [IN_WIDTH-1:0] IN_ZERO = {IN_WIDTH{1'b0}};

    logic [IN_WIDTH-1:0]                sync1_q, sync1_d, sync2_q, sync2_d;
    logic [IN_WIDTH-1:0]                cap_q, cap_d, pol_q, pol_d;
    logic [NUM_HARTS-1:0][IN_WIDTH-1:0] mask_q, mask_d;
    logic [OUT_WIDTH-1:0]               out_q, out_d;
    logic [NUM_HARTS-1:0]               irq_q, irq_d;
    logic [31:0]                        rdata_q, rdata_d;

    logic [IN_WIDTH-1:0]  stable_cur_s, stable_nxt_s;
    logic [IN_WIDTH-1:0]  edge_s, w1c_s, wd_in_s;
    logic [OUT_WIDTH-1:0] wd_out_s;
    logic [31:0]          rd_mux_s;
    logic                 unused_wd_s;

    assign wd_in_s     = avs_writedata[IN_WIDTH-1:0];
    assign wd_out_s    = avs_writedata[OUT_WIDTH-1:0];
    assign unused_wd_s = ^avs_writedata;

    // Two-stage synchroniser for the raw asynchronous pins
    always_comb begin
        sync1_d = pio_in_export;
        sync2_d = sync1_q;
    end

`ifdef MULTI_PIO_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [IN_WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]            stable_q, stable_d;

    // Per-bit debounce: accept a new level only after it has differed long enough
    always_comb begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i]    = CNT_ZERO;
                stable_d[i] = stable_q[i];
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]    = CNT_ZERO;
                stable_d[i] = sync2_q[i];
            end else begin
                cnt_d[i]    = cnt_q[i] + CNT_ONE;
                stable_d[i] = stable_q[i];
            end
        end
    end

    // Debounce counters and accepted input levels
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
            stable_q <= IN_RESET;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_cur_s = stable_q;
    assign stable_nxt_s = stable_d;
`else
    assign stable_cur_s = sync2_q;
    assign stable_nxt_s = sync2_d;
`endif

    // Edge detect, register writes, read mux and interrupt combine
    always_comb begin
        // Selected-direction edges of the accepted input at this clock edge
        edge_s = ((stable_nxt_s & ~stable_cur_s) & ~pol_q) |
                 ((~stable_nxt_s & stable_cur_s) & pol_q);
        w1c_s  = (avs_write && (avs_address == ADDR_EDGE_CAP)) ? wd_in_s : IN_ZERO;
        // A new edge wins over a simultaneous clear
        cap_d  = (cap_q & ~w1c_s) | edge_s;

        out_d = out_q;
        pol_d = pol_q;
        if (avs_write) begin
            case (avs_address)
                ADDR_DATA_OUT: out_d = wd_out_s;
                ADDR_SET_OUT:  out_d = out_q | wd_out_s;
                ADDR_CLR_OUT:  out_d = out_q & ~wd_out_s;
                ADDR_EDGE_POL: pol_d = wd_in_s;
                default:       out_d = out_q;
            endcase
        end else begin
            out_d = out_q;
        end

        for (int h = 0; h < NUM_HARTS; h++) begin
            if (avs_write && (avs_address == 4'(MASK_BASE + h))) begin
                mask_d[h] = wd_in_s;
            end else begin
                mask_d[h] = mask_q[h];
            end
            irq_d[h] = |(cap_q & mask_q[h]);
        end

        // Reads see the state before any same-cycle write
        rd_mux_s = 32'h0000_0000;
        case (avs_address)
            ADDR_DATA_IN:  rd_mux_s = 32'(stable_cur_s);
            ADDR_DATA_OUT: rd_mux_s = 32'(out_q);
            ADDR_EDGE_CAP: rd_mux_s = 32'(cap_q);
            ADDR_EDGE_POL: rd_mux_s = 32'(pol_q);
            default: begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                    if (avs_address == 4'(MASK_BASE + h)) begin
                        rd_mux_s = 32'(mask_q[h]);
                    end else begin
                        rd_mux_s = rd_mux_s;
                    end
                end
            end
        endcase

        if (avs_read) begin
            rdata_d = rd_mux_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q <= IN_RESET;
            sync2_q <= IN_RESET;
            cap_q   <= IN_ZERO;
            pol_q   <= IN_ZERO;
            for (int h = 0; h < NUM_HARTS; h++) begin
                mask_q[h] <= IN_ZERO;
            end
            out_q   <= OUT_RESET;
            irq_q   <= {NUM_HARTS{1'b0}};
            rdata_q <= 32'h0000_0000;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cap_q   <= cap_d;
            pol_q   <= pol_d;
            mask_q  <= mask_d;
            out_q   <= out_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign avs_readdata   = rdata_q;
    assign pio_out_export = out_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_multi_pio.sv
// Directed self-checking bench for multi_pio (IN/OUT width 4, two harts,
// DEBOUNCE_CYCLES=4). Expected timings follow the build's debounce option.
module tb_multi_pio;

`ifdef MULTI_PIO_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  pins;
    logic [3:0]  pout;
    logic [1:0]  irq;
    logic [31:0] d;
    int          vectors = 0;
    int          miscompares = 0;

    multi_pio #(
        .IN_WIDTH(4), .OUT_WIDTH(4), .NUM_HARTS(2), .DEBOUNCE_CYCLES(4),
        .IN_RESET(4'hF), .OUT_RESET(4'h5)
    ) dut (
        .clk_clk(clk), .reset_reset(rst),
        .avs_address(addr), .avs_read(rd_en), .avs_write(wr_en),
        .avs_writedata(wdata), .avs_readdata(rdata),
        .pio_in_export(pins), .pio_out_export(pout), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] v);
        addr  = a;
        wdata = v;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        addr  = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        v     = rdata;
    endtask

    initial begin
        rst = 1'b1; addr = 4'd0; rd_en = 1'b0; wr_en = 1'b0;
        wdata = 32'h0; pins = 4'hF;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_out", 32'(pout), 32'h5);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rd(4'd0, d); chk("rst_data_in", d, 32'h0000_000F);
        rd(4'd4, d); chk("rst_edge_cap", d, 32'h0);

        // Output register operations
        wr(4'd1, 32'h0000_000A); chk("out_write", 32'(pout), 32'hA);
        wr(4'd2, 32'h0000_0001); chk("out_set", 32'(pout), 32'hB);
        wr(4'd3, 32'h0000_0008); chk("out_clr", 32'(pout), 32'h3);
        rd(4'd1, d);  chk("rd_data_out", d, 32'h3);
        rd(4'd15, d); chk("rd_unmapped", d, 32'h0);
        rd(4'd2, d);  chk("rd_set_out", d, 32'h0);
        // Same-cycle read and write: read returns pre-write value
        addr = 4'd1; wdata = 32'h0000_000C; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rw_read_old", rdata, 32'h3);
        chk("rw_write_new", 32'(pout), 32'hC);
        // Upper bits ignored on write and read as zero
        wr(4'd1, 32'hFFFF_FFF0); rd(4'd1, d); chk("out_upper_bits", d, 32'h0);

        // Polarity and masks
        wr(4'd5, 32'h1);
        wr(4'd7, 32'h1);
        wr(4'd6, 32'h0);
        wr(4'd8, 32'hF);
        rd(4'd5, d); chk("rd_pol", d, 32'h1);
        rd(4'd7, d); chk("rd_mask1", d, 32'h1);
        rd(4'd6, d); chk("rd_mask0", d, 32'h0);
        rd(4'd8, d); chk("rd_addr8", d, 32'h0);

`ifdef MULTI_PIO_DEBOUNCE_EN
        // 3-cycle glitch rejected
        pins = 4'hE; repeat (3) tick(); pins = 4'hF;
        repeat (8) tick();
        rd(4'd0, d); chk("glitch_data_in", d, 32'hF);
        rd(4'd4, d); chk("glitch_edge_cap", d, 32'h0);
        chk("glitch_irq", 32'(irq), 32'h0);
`else
        // 1-cycle glitch captured
        pins = 4'hE; tick(); pins = 4'hF;
        repeat (4) tick();
        rd(4'd4, d); chk("glitch_edge_cap", d, 32'h1);
        chk("glitch_irq", 32'(irq), 32'h2);
        rd(4'd0, d); chk("glitch_data_in", d, 32'hF);
        wr(4'd4, 32'h1); tick();
        chk("glitch_irq_clr", 32'(irq), 32'h0);
`endif

        // Pin0 held low: DATA_IN changes exactly LAT cycles after the pin
        pins = 4'hE;
        repeat (LAT - 1) tick();
        rd(4'd0, d); chk("lat_before", d, 32'hF);
        chk("irq_before", 32'(irq), 32'h0);
        rd(4'd0, d); chk("lat_after", d, 32'hE);
        chk("irq_set", 32'(irq), 32'h2);
        rd(4'd4, d); chk("cap_fall", d, 32'h1);
        wr(4'd4, 32'h1); chk("irq_hold", 32'(irq), 32'h2);
        tick();          chk("irq_clr", 32'(irq), 32'h0);
        rd(4'd4, d); chk("cap_cleared", d, 32'h0);

        // Rising edge on pin0 ignored with falling polarity
        pins = 4'hF; repeat (LAT + 2) tick();
        rd(4'd4, d); chk("cap_rise_ignored", d, 32'h0);
        rd(4'd0, d); chk("din_restored", d, 32'hF);

        // Bit2 rising capture, then W1C colliding with a new edge
        pins = 4'hB; repeat (LAT + 2) tick();
        pins = 4'hF; repeat (LAT + 2) tick();
        rd(4'd4, d); chk("cap_bit2", d, 32'h4);
        chk("irq_bit2_masked", 32'(irq), 32'h0);
        pins = 4'hB; repeat (LAT + 2) tick();
        pins = 4'hF; repeat (LAT - 1) tick();
        wr(4'd4, 32'h4);
        rd(4'd4, d); chk("w1c_vs_edge", d, 32'h4);
        wr(4'd4, 32'h4);
        rd(4'd4, d); chk("w1c_plain", d, 32'h0);

        // Reset asserted mid-operation
        wr(4'd1, 32'hC);
        pins = 4'hE; repeat (2) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_out", 32'(pout), 32'h5);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        rd(4'd0, d); chk("mid_rst_din", d, 32'hF);
        rd(4'd5, d); chk("mid_rst_pol", d, 32'h0);
        rd(4'd7, d); chk("mid_rst_mask1", d, 32'h0);
        pins = 4'hF;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
